// File: rtl/carrier_pkg.sv
// Shared definitions for the carrier burst generator: FSM state encoding and
// default counter widths.
package carrier_pkg;

  localparam int CARRIER_WIDTH_DEF       = 8;
  localparam int CARRIER_BURST_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } carrier_state_e;

endpackage

// File: rtl/carrier_burst_generator.sv
// Programmable carrier generator: emits bursts of high/low periods with
// shadow-buffered counts that only take effect at period boundaries.
module carrier_burst_generator
  import carrier_pkg::*;
#(
  parameter int WIDTH       = CARRIER_WIDTH_DEF,
  parameter int BURST_WIDTH = CARRIER_BURST_WIDTH_DEF
) (
  input  logic                   clock_in,
  input  logic                   reset_n_in,
  input  logic                   enable_in,
  input  logic                   forced_in,
  input  logic [WIDTH-1:0]       high_count_in,
  input  logic [WIDTH-1:0]       low_count_in,
  input  logic [BURST_WIDTH-1:0] burst_count_in,
  input  logic                   load_in,
  input  logic                   start_in,
  output logic                   busy_out,
  output logic                   done_out,
  output logic                   ctc_out
);

  carrier_state_e         state_q, state_d;
  logic [WIDTH-1:0]       phase_q, phase_d;
  logic [BURST_WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0]       act_high_q, act_high_d, act_low_q, act_low_d;
  logic [BURST_WIDTH-1:0] act_burst_q, act_burst_d;
  logic [WIDTH-1:0]       sh_high_q, sh_high_d, sh_low_q, sh_low_d;
  logic [BURST_WIDTH-1:0] sh_burst_q, sh_burst_d;
  logic                   pending_q, pending_d;
  logic                   done_q, done_d;
  logic [BURST_WIDTH:0]   period_inc;

  // One bit wider so a saturated period counter can never alias a burst length.
  assign period_inc = {1'b0, period_q} + {{BURST_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    period_d    = period_q;
    act_high_d  = act_high_q;
    act_low_d   = act_low_q;
    act_burst_d = act_burst_q;
    sh_high_d   = sh_high_q;
    sh_low_d    = sh_low_q;
    sh_burst_d  = sh_burst_q;
    pending_d   = pending_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_in && enable_in) begin
          state_d     = ST_HIGH;
          act_high_d  = sh_high_q;
          act_low_d   = sh_low_q;
          act_burst_d = sh_burst_q;
          pending_d   = 1'b0;
          phase_d     = '0;
          period_d    = '0;
        end
      end
      ST_HIGH: begin
        if (!enable_in) begin
          state_d = ST_IDLE;
        end else if (phase_q == act_high_q) begin
          state_d = ST_LOW;
          phase_d = '0;
        end else begin
          phase_d = phase_q + WIDTH'(1);
        end
      end
      ST_LOW: begin
        if (!enable_in) begin
          state_d = ST_IDLE;
        end else if (phase_q == act_low_q) begin
          if (act_burst_q != '0 && period_inc == {1'b0, act_burst_q}) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_HIGH;
            phase_d = '0;
            if (period_q != '1) period_d = period_inc[BURST_WIDTH-1:0];
            // New counts only take effect here so the carrier never glitches.
            if (pending_q) begin
              act_high_d  = sh_high_q;
              act_low_d   = sh_low_q;
              act_burst_d = sh_burst_q;
              pending_d   = 1'b0;
            end
          end
        end else begin
          phase_d = phase_q + WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_in) begin
      sh_high_d  = high_count_in;
      sh_low_d   = low_count_in;
      sh_burst_d = burst_count_in;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      period_q    <= '0;
      act_high_q  <= '0;
      act_low_q   <= '0;
      act_burst_q <= '0;
      sh_high_q   <= '0;
      sh_low_q    <= '0;
      sh_burst_q  <= '0;
      pending_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      period_q    <= period_d;
      act_high_q  <= act_high_d;
      act_low_q   <= act_low_d;
      act_burst_q <= act_burst_d;
      sh_high_q   <= sh_high_d;
      sh_low_q    <= sh_low_d;
      sh_burst_q  <= sh_burst_d;
      pending_q   <= pending_d;
      done_q      <= done_d;
    end
  end

  assign busy_out = (state_q != ST_IDLE);
  assign done_out = done_q;
  // Dropping enable hands the output to forced_in before the state catches up.
  assign ctc_out  = (state_q == ST_IDLE || !enable_in) ? forced_in : (state_q == ST_HIGH);

endmodule

// File: tb/tb_carrier_burst_generator.sv
// Randomized and directed bench for carrier_burst_generator against a
// period-arithmetic reference model.
module tb_carrier_burst_generator;

  localparam int W  = 8;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          forced = 1'b0;
  logic          load = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  hc = '0;
  logic [W-1:0]  lc = '0;
  logic [BW-1:0] bc = '0;
  logic          busy, done, ctc;

  carrier_burst_generator #(.WIDTH(W), .BURST_WIDTH(BW)) dut (
    .clock_in(clk), .reset_n_in(reset_n), .enable_in(enable), .forced_in(forced),
    .high_count_in(hc), .low_count_in(lc), .burst_count_in(bc),
    .load_in(load), .start_in(start),
    .busy_out(busy), .done_out(done), .ctc_out(ctc)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cnt_hi, cnt_lo, cnt_done;

  // Reference state: position t within the current carrier period.
  bit m_busy, m_done, m_pend;
  int t, periods, ah, al, ab, sh_h, sh_l, sh_b;
  localparam int PMAX = (1 << BW) - 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_pend = 0;
    t = 0; periods = 0; ah = 0; al = 0; ab = 0; sh_h = 0; sh_l = 0; sh_b = 0;
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_done = 0;
    if (!m_busy) begin
      if (start && enable) begin
        m_busy = 1; t = 0; periods = 0;
        ah = sh_h; al = sh_l; ab = sh_b; m_pend = 0;
      end
    end else if (!enable) begin
      m_busy = 0;
    end else if (t == ah + al + 1) begin
      if (ab != 0 && periods + 1 == ab) begin
        m_busy = 0; m_done = 1;
      end else begin
        t = 0;
        if (periods < PMAX) periods++;
        if (m_pend) begin
          ah = sh_h; al = sh_l; ab = sh_b; m_pend = 0;
        end
      end
    end else begin
      t++;
    end
    if (load) begin
      sh_h = int'(hc); sh_l = int'(lc); sh_b = int'(bc); m_pend = 1;
    end
  endtask

  task automatic check_outputs();
    logic exp_ctc;
    exp_ctc = (!m_busy || !enable) ? forced : (t <= ah);
    chk("ctc_out", 32'(ctc), 32'(exp_ctc));
    chk("busy_out", 32'(busy), 32'(m_busy));
    chk("done_out", 32'(done), 32'(m_done));
    if (busy) begin
      if (ctc) cnt_hi++;
      else cnt_lo++;
    end
    if (done) cnt_done++;
  endtask

  // Inputs are set just after a falling edge; this checks, then advances one clock.
  task automatic cycle();
    if (!reset_n) model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clr_cnt();
    cnt_hi = 0; cnt_lo = 0; cnt_done = 0;
  endtask

  task automatic do_load(input int h, input int l, input int b);
    hc = W'(h); lc = W'(l); bc = BW'(b);
    load = 1; cycle(); load = 0;
  endtask

  task automatic do_start();
    start = 1; cycle(); start = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    model_reset();
    clr_cnt();
    @(negedge clk);
    // Reset state
    forced = 1;
    run(2);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ctc_forced", 32'(ctc), 32'd1);
    forced = 0;
    reset_n = 1;
    enable = 1;
    run(2);

    // Two-period burst: 4 high, 6 low, twice
    do_load(3, 5, 2);
    do_start();
    clr_cnt();
    run(25);
    chk("burst2_high_cycles", 32'(cnt_hi), 32'd8);
    chk("burst2_low_cycles", 32'(cnt_lo), 32'd12);
    chk("burst2_done_pulses", 32'(cnt_done), 32'd1);
    chk("burst2_busy_after", 32'(busy), 32'd0);

    // Continuous 1/0 toggling
    do_load(0, 0, 0);
    do_start();
    clr_cnt();
    run(1000);
    chk("cont_high_cycles", 32'(cnt_hi), 32'd500);
    chk("cont_low_cycles", 32'(cnt_lo), 32'd500);
    chk("cont_no_done", 32'(cnt_done), 32'd0);
    enable = 0; cycle(); enable = 1;

    // Mid-HIGH reload only affects the following period
    do_load(2, 2, 2);
    do_start();
    clr_cnt();
    cycle();
    do_load(7, 2, 2);
    run(25);
    chk("reload_high_cycles", 32'(cnt_hi), 32'd11);
    chk("reload_low_cycles", 32'(cnt_lo), 32'd6);
    chk("reload_done_pulses", 32'(cnt_done), 32'd1);

    // Enable drop in LOW with forced high; start while disabled ignored
    do_load(2, 3, 0);
    do_start();
    run(4);
    clr_cnt();
    enable = 0; forced = 1;
    #1 chk("abort_ctc_immediate", 32'(ctc), 32'd1);
    cycle();
    chk("abort_busy", 32'(busy), 32'd0);
    start = 1; cycle(); start = 0;
    cycle();
    chk("abort_start_ignored", 32'(busy), 32'd0);
    chk("abort_no_done", 32'(cnt_done), 32'd0);
    forced = 0; enable = 1;

    // Asynchronous reset mid-burst, then start with cleared shadow
    do_load(4, 4, 3);
    do_start();
    run(3);
    #3 reset_n = 0;
    #1;
    model_reset();
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_ctc", 32'(ctc), 32'(forced));
    @(negedge clk);
    clr_cnt();
    run(2);
    reset_n = 1;
    do_start();
    run(6);
    chk("areset_zero_counts_high", 32'(cnt_hi), 32'd3);
    chk("areset_no_done", 32'(cnt_done), 32'd0);
    enable = 0; cycle(); enable = 1;

    // Full-scale phases
    do_load(255, 255, 1);
    do_start();
    clr_cnt();
    run(520);
    chk("max_high_cycles", 32'(cnt_hi), 32'd256);
    chk("max_low_cycles", 32'(cnt_lo), 32'd256);
    chk("max_done_pulses", 32'(cnt_done), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      enable  = ($urandom_range(0, 19) != 0);
      forced  = 1'($urandom_range(0, 1));
      start   = ($urandom_range(0, 7) == 0);
      load    = ($urandom_range(0, 9) == 0);
      reset_n = ($urandom_range(0, 399) != 0);
      if (load) begin
        hc = W'($urandom_range(0, 5));
        lc = W'($urandom_range(0, 5));
        bc = BW'($urandom_range(0, 4));
      end
      cycle();
    end
    reset_n = 1; load = 0; start = 0;
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/carrier_burst_generator.md
CARRIER_BURST_GENERATOR -- requirements
Module: carrier_burst_generator

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of high/low phase counts.
REQ-002 SHALL have parameter BURST_WIDTH, default 16: width of the burst period count.
REQ-003 SHALL have port clock_in, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n_in, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port enable_in, input, 1: generation permitted when high; low aborts to IDLE.
REQ-006 SHALL have port forced_in, input, 1: ctc_out value while IDLE.
REQ-007 SHALL have port high_count_in, input, WIDTH: high-phase length minus 1, in clocks.
REQ-008 SHALL have port low_count_in, input, WIDTH: low-phase length minus 1, in clocks.
REQ-009 SHALL have port burst_count_in, input, BURST_WIDTH: carrier periods per burst; 0 means continuous.
REQ-010 SHALL have port load_in, input, 1: writes the three count inputs into shadow registers.
REQ-011 SHALL have port start_in, input, 1: begins a burst.
REQ-012 SHALL have port busy_out, output, 1: high in HIGH or LOW state.
REQ-013 SHALL have port done_out, output, 1: one-cycle pulse on burst completion.
REQ-014 SHALL have port ctc_out, output, 1: carrier output.

Function
REQ-015 SHALL implement FSM states IDLE, HIGH, LOW; ctc_out = 1 in HIGH, 0 in LOW, forced_in (combinational) in IDLE.
REQ-016 load_in high SHALL write shadow registers at that edge in any state and SHALL set a pending flag.
REQ-017 start_in with enable_in high in IDLE SHALL copy shadow to active registers, clear pending, zero phase and period counters, and enter HIGH at the same edge; ctc_out high from the next cycle.
REQ-018 start_in SHALL be ignored while busy_out is high or enable_in is low.
REQ-019 HIGH SHALL last active_high+1 cycles, LOW active_low+1 cycles; carrier period = high+low+2 cycles.
REQ-020 At the last LOW cycle, if active burst != 0 and completed periods+1 == active burst: enter IDLE, pulse done_out for exactly the next cycle.
REQ-021 Otherwise at the last LOW cycle: increment period counter and enter HIGH; if pending is set, reload active from shadow and clear pending (glitch-free update only at period boundaries).
REQ-022 load_in coinciding with a period boundary SHALL reload from the pre-edge shadow value and leave pending set.
REQ-023 Continuous mode (burst 0) SHALL never assert done_out; period counter SHALL saturate, never wrap.
REQ-024 enable_in low in HIGH or LOW SHALL enter IDLE at the next edge without done_out; ctc_out follows forced_in combinationally at once.
REQ-025 Counts of 0 SHALL give 1-cycle phases; all-ones SHALL give 2^WIDTH-cycle phases; counters SHALL not overflow.

Reset
REQ-026 reset_n_in low SHALL asynchronously force IDLE, clear counters, active, shadow and pending registers, and force done_out = 0; busy_out = 0, ctc_out = forced_in.
REQ-027 Reset mid-burst SHALL abort without done_out; the first start_in after release uses all-zero counts unless load_in is issued.

Structure
REQ-028 State enum and default WIDTH/BURST_WIDTH constants SHALL reside in shared package carrier_pkg.
REQ-029 The block SHALL be flat; no sub-module.

Verification
REQ-030 Load high=3, low=5, burst=2, start -> ctc_out 1 for 4 cycles, 0 for 6, twice; done_out pulses once; busy_out low afterward.
REQ-031 Burst=0, high=0, low=0 -> continuous 1/0 toggling for 1000 cycles; done_out never high.
REQ-032 Mid-HIGH load high=7 -> current period unchanged; next period high for 8 cycles.
REQ-033 enable_in dropped in LOW, forced_in=1 -> ctc_out=1 the same cycle, IDLE next edge, no done_out; start while disabled ignored.
REQ-034 reset_n_in low mid-burst (asynchronous to clock) -> immediate IDLE, busy_out=0, shadow cleared.
REQ-035 high=255, low=255, burst=1 -> 256 high, 256 low cycles, then done_out.
